// File: rtl/stream_router.sv
// stream_router: steers whole valid/ready packets from one input stream to one of NUM_PORTS outputs.
// Optional STREAM_ROUTER_DROP_INVALID_EN adds a dropped pulse and discards packets with out-of-range destinations.
module stream_router #(
  parameter int NUM_PORTS  = 9,
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [SEL_WIDTH-1:0]  in_dest,
  output logic [NUM_PORTS-1:0]  out_valid,
  input  logic [NUM_PORTS-1:0]  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [SEL_WIDTH-1:0]  select,
  output logic                  active
`ifdef STREAM_ROUTER_DROP_INVALID_EN
  ,
  output logic                  dropped
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;
  localparam logic [SEL_WIDTH:0]   NP        = (SEL_WIDTH+1)'(NUM_PORTS);
  localparam logic [SEL_WIDTH-1:0] LAST_PORT = SEL_WIDTH'(NUM_PORTS - 1);
`ifdef STREAM_ROUTER_DROP_INVALID_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif
  state_t                state_q, state_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d, dest_c;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d, valid_q, valid_d;
  logic                  bad_dest, drop_mode, fire_in, drain, load;
  // drop_mode: the current input beat belongs to a packet that is swallowed, not routed
  always_comb begin
    bad_dest  = {1'b0, in_dest} >= NP;
    dest_c    = bad_dest ? LAST_PORT : in_dest;
    drop_mode = DROP_EN && (state_q == DROP || (state_q == IDLE && bad_dest));
    drain     = valid_q && out_ready[sel_q];
    in_ready  = !rst && (drop_mode || !valid_q || out_ready[sel_q]);
    fire_in   = in_valid && in_ready;
    load      = fire_in && !drop_mode;
    sel_d     = (load && state_q == IDLE) ? dest_c : sel_q;
    data_d    = load ? in_data : data_q;
    last_d    = load ? in_last : last_q;
    valid_d   = load || (valid_q && !drain);
    state_d   = !fire_in ? state_q :
                in_last ? IDLE :
                state_q != IDLE ? state_q :
                drop_mode ? DROP : BUSY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end
`ifdef STREAM_ROUTER_DROP_INVALID_EN
  logic dropped_q, dropped_d;
  always_comb dropped_d = fire_in && drop_mode && in_last;
  always_ff @(posedge clk) begin
    if (rst) dropped_q <= 1'b0;
    else dropped_q <= dropped_d;
  end
  assign dropped = dropped_q;
`endif
  assign out_valid = valid_q ? (NUM_PORTS'(1'b1) << sel_q) : '0;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign select    = sel_q;
  assign active    = (state_q != IDLE) || valid_q;
endmodule

// File: doc/stream_router.md
Name: stream_router

Overview:
- Packet router that is the dispatch-side counterpart of the round-robin arbiter.
- Takes one input stream (valid/ready, data, last, destination) and steers whole packets to one of NUM_PORTS output ports.
- The route is locked on a packet's first beat and held until its last beat.
- Used after a shared resource to return responses to the requesters that the arbiter merged.

Parameters:
- NUM_PORTS, 9, number of output ports (>=1).
- DATA_WIDTH, 8, payload width in bits.
- SEL_WIDTH, (NUM_PORTS>1 ? $clog2(NUM_PORTS) : 1), width of destination/select. Derived; do not override.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  router accepts the input beat this cycle.
- in_data  input  DATA_WIDTH  input payload.
- in_last  input  1  final beat of the packet.
- in_dest  input  SEL_WIDTH  destination port; sampled only on a packet's first beat.
- out_valid  output  NUM_PORTS  one-hot valid; bit i means port i holds a beat.
- out_ready  input  NUM_PORTS  per-port ready.
- out_data  output  DATA_WIDTH  payload, shared by all ports.
- out_last  output  1  last flag, shared by all ports.
- select  output  SEL_WIDTH  currently locked route.
- active  output  1  packet open or output register occupied.

Behaviour:
- Reset values: in_ready=0 during reset; out_valid=0, out_data=0, out_last=0, select=0, active=0. State=IDLE.
- Reset is honoured mid-packet: the open packet and any held beat are discarded; no beat appears after reset deasserts.
- Output register: a single stage, so latency is 1 cycle from input acceptance to out_valid.
- Ready rule: in_ready = !rst && (out_valid==0 || out_ready[select]). This gives full throughput, one beat per cycle, while the target port is ready.
- Handshakes: an input beat transfers when in_valid && in_ready. An output beat transfers when out_valid[select] && out_ready[select].
- Output signals hold stable while valid && !ready.
- State IDLE (no packet open): an accepted beat latches select<=in_dest and loads the output register.
  - If in_last=1, stay in IDLE (single-beat packet).
  - Otherwise go to BUSY.
- State BUSY: accepted beats go to the latched select; in_dest is ignored. An accepted beat with in_last=1 returns to IDLE.
- Back-to-back packets: a new packet's first beat may be accepted in the cycle after the previous last beat. Its select update takes effect together with the loading of the output register. No bubble is inserted even when the destination changes.
- Simultaneous events: output drain and input load in the same cycle give the register the new beat, with out_valid staying set.
- Drain without load clears out_valid.
- active = (state==BUSY) || (out_valid!=0).
- Out-of-range in_dest (>= NUM_PORTS), default build: routed to port NUM_PORTS-1.
- out_valid is always one-hot or zero.

Optional Feature:
- Macro: STREAM_ROUTER_DROP_INVALID_EN.
- When defined, an extra output port is added: dropped, 1 bit, reset value 0.
- A packet whose first-beat in_dest >= NUM_PORTS is consumed with in_ready=1 on every beat and never loaded into the output register.
- dropped pulses high for 1 cycle after that packet's last beat is accepted.
- When undefined, out-of-range destinations clamp to port NUM_PORTS-1 and the dropped port does not exist.

Test Plan:
- Reset: hold rst for 10 cycles with in_valid=1 -> in_ready=0, out_valid=9'b0, active=0 throughout. Reassert rst mid-packet -> out_valid=0 on the next cycle.
- Single-beat packet: in_dest=5, data=8'hA5, last=1, out_ready=all ones -> the next cycle shows out_valid=9'b000100000, out_data=8'hA5, out_last=1, select=5. The cycle after that shows out_valid=0 and active=0.
- Route lock: 4-beat packet with in_dest=2; change in_dest to 7 on beats 2-4 -> all 4 beats appear on out_valid[2]; select=2 throughout.
- Backpressure: out_ready[3]=0 for 5 cycles during a packet to port 3 -> in_ready=0; out_data stable; no beat lost or duplicated once ready returns.
- Back-to-back: packet A (2 beats to port 0) is followed immediately by packet B (3 beats to port 8) with all ports ready -> 5 consecutive output beats; out_valid switches from 9'b000000001 to 9'b100000000 with no idle cycle.
- Invalid destination: in_dest=12 on a 2-beat packet. Default build -> beats appear on port 8. With STREAM_ROUTER_DROP_INVALID_EN -> out_valid stays 0 and dropped=1 for exactly one cycle.
